// File: rtl/axi_pack_mem_responder_pkg.sv
// axi_pack_mem_responder_pkg: shared types and constants for the memory responder.
// Holds the ID-extended AXI4 channel structs (9-bit ID), the responder FSM states,
// the default array depth, the burst/response encodings and a response-priority helper.
package axi_pack_mem_responder_pkg;

    localparam int unsigned AddrWidth       = 32;
    localparam int unsigned DataWidth       = 32;
    localparam int unsigned IdWidth         = 9;
    localparam int unsigned UserWidth       = 1;
    localparam int unsigned StrbWidth       = DataWidth / 8;
    localparam int unsigned DataAlign       = $clog2(StrbWidth);
    localparam int unsigned MemWordsDefault = 1024;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [UserWidth-1:0] ssr_user_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        ssr_user_t            user;
    } axi_idext_ax_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        ssr_user_t            user;
    } axi_idext_w_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
        ssr_user_t          user;
    } axi_idext_b_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        ssr_user_t            user;
    } axi_idext_r_t;

    typedef struct packed {
        axi_idext_ax_t aw;
        logic          aw_valid;
        axi_idext_w_t  w;
        logic          w_valid;
        logic          b_ready;
        axi_idext_ax_t ar;
        logic          ar_valid;
        logic          r_ready;
    } axi_idext_req_t;

    typedef struct packed {
        logic          aw_ready;
        logic          ar_ready;
        logic          w_ready;
        logic          b_valid;
        axi_idext_b_t  b;
        logic          r_valid;
        axi_idext_r_t  r;
    } axi_idext_rsp_t;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} resp_state_e;

    // DECERR dominates SLVERR, which dominates OKAY.
    function automatic logic [1:0] resp_code(input logic dec, input logic slv);
        return dec ? RESP_DECERR : slv ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_pack_mem_responder_sram.sv
// axi_pack_mem_responder_sram: single-port word array with per-byte write enables.
// Ports: clk; req/we select a read or write of word addr; wdata/be are the write
// data and byte enables; rdata is registered and only updates on a read, so it
// holds the last word read while no new read is issued. Contents are never reset.
module axi_pack_mem_responder_sram #(
    parameter int unsigned Words = 1024,
    parameter int unsigned Width = 32,
    localparam int unsigned IdxW = $clog2(Words),
    localparam int unsigned BeW  = Width / 8
) (
    input  logic             clk,
    input  logic             req,
    input  logic             we,
    input  logic [IdxW-1:0]  addr,
    input  logic [Width-1:0] wdata,
    input  logic [BeW-1:0]   be,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Words];

    always_ff @(posedge clk) begin
        if (req && we) begin
            for (int i = 0; i < BeW; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (req && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/axi_pack_mem_responder.sv
// axi_pack_mem_responder: AXI4 subordinate serving one burst at a time from an internal SRAM.
// Ports: clk_i clock; rst_ni async active-low reset; axi_req_i AW/W/AR channels, valids
// and B/R readies; axi_rsp_o AW/W/AR readies, B/R channels and valids.
// Build option AXI_PACK_MEM_RESP_ERR_EN: out-of-range word indices get DECERR (writes
// dropped, reads return 0); without it the index wraps modulo MemWords.
module axi_pack_mem_responder
    import axi_pack_mem_responder_pkg::*;
#(
    parameter int unsigned          MemWords  = MemWordsDefault,
    parameter logic [AddrWidth-1:0] BaseAddr  = 32'h0000_0000,
    parameter type                  axi_req_t = axi_idext_req_t,
    parameter type                  axi_rsp_t = axi_idext_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);

    localparam int unsigned MemIdxW = $clog2(MemWords);
    typedef logic [AddrWidth-DataAlign-1:0] widx_t;

    resp_state_e state_q, state_d;
    logic run_q, prio_rd_q, slv_q, dec_q;
    logic r_valid_q, r_last_q, r_zero_q;
    logic [1:0] r_resp_q, burst_q;
    logic [IdWidth-1:0] id_q;
    logic [7:0] len_q, cnt_q;
    widx_t idx_q, idx_nxt, aw_idx, ar_idx, rd_idx, sram_idx;
    logic idle, aw_rdy, ar_rdy, aw_go, ar_go;
    logic w_hs, w_at_len, w_end, w_bad, w_oor, mem_we;
    logic r_hs, r_issue, r_oor, rd_wrap;
    logic [DataWidth-1:0] rdata;
    logic unused_ok;

    // run_q keeps every ready low while reset is held and for the first cycle after.
    assign idle   = run_q && state_q == IDLE;
    assign aw_rdy = idle && !(axi_req_i.ar_valid && prio_rd_q);
    assign ar_rdy = idle && !(axi_req_i.aw_valid && !prio_rd_q);
    assign aw_go  = aw_rdy && axi_req_i.aw_valid;
    assign ar_go  = ar_rdy && axi_req_i.ar_valid;

    assign aw_idx  = widx_t'((axi_req_i.aw.addr - BaseAddr) >> DataAlign);
    assign ar_idx  = widx_t'((axi_req_i.ar.addr - BaseAddr) >> DataAlign);
    assign idx_nxt = burst_q == BURST_INCR ? idx_q + widx_t'(1) : idx_q;

    assign w_hs     = state_q == WR_DATA && axi_req_i.w_valid;
    assign w_at_len = cnt_q == len_q;
    assign w_end    = w_hs && (axi_req_i.w.last || w_at_len);
    assign w_bad    = w_hs && (axi_req_i.w.last != w_at_len);
    assign mem_we   = w_hs && burst_q != BURST_WRAP && !w_oor;

    // The word about to be read: first beat straight from AR, later beats from the walker.
    assign r_hs    = r_valid_q && axi_req_i.r_ready;
    assign r_issue = ar_go || (state_q == RD_DATA && r_hs && !r_last_q);
    assign rd_idx  = idle ? ar_idx : idx_nxt;
    assign rd_wrap = idle ? axi_req_i.ar.burst == BURST_WRAP : burst_q == BURST_WRAP;
    assign sram_idx = state_q == WR_DATA ? idx_q : rd_idx;

`ifdef AXI_PACK_MEM_RESP_ERR_EN
    assign w_oor = idx_q >= widx_t'(MemWords);
    assign r_oor = rd_idx >= widx_t'(MemWords);
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    assign unused_ok = ^{axi_req_i, idx_q};

    axi_pack_mem_responder_sram #(.Words(MemWords), .Width(DataWidth)) i_sram (
        .clk   (clk_i),
        .req   (mem_we || r_issue),
        .we    (mem_we),
        .addr  (sram_idx[MemIdxW-1:0]),
        .wdata (axi_req_i.w.data),
        .be    (axi_req_i.w.strb),
        .rdata (rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            prio_rd_q <= 1'b0;
            id_q      <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            slv_q     <= 1'b0;
            dec_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_zero_q  <= 1'b0;
            r_resp_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (aw_go || ar_go) begin
                prio_rd_q <= aw_go;
                id_q      <= aw_go ? axi_req_i.aw.id : axi_req_i.ar.id;
                idx_q     <= aw_go ? aw_idx : ar_idx;
                len_q     <= aw_go ? axi_req_i.aw.len : axi_req_i.ar.len;
                burst_q   <= aw_go ? axi_req_i.aw.burst : axi_req_i.ar.burst;
                cnt_q     <= '0;
                slv_q     <= aw_go && axi_req_i.aw.burst == BURST_WRAP;
                dec_q     <= 1'b0;
            end
            if (w_hs) begin
                idx_q <= idx_nxt;
                cnt_q <= cnt_q + 8'd1;
                slv_q <= slv_q | w_bad;
                dec_q <= dec_q | w_oor;
            end
            if (r_issue) begin
                r_valid_q <= 1'b1;
                r_last_q  <= ar_go ? axi_req_i.ar.len == 8'd0 : cnt_q + 8'd1 == len_q;
                r_zero_q  <= r_oor;
                r_resp_q  <= resp_code(r_oor, rd_wrap);
                if (!ar_go) begin
                    idx_q <= idx_nxt;
                    cnt_q <= cnt_q + 8'd1;
                end
            end else if (r_hs) begin
                r_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = aw_go ? WR_DATA : ar_go ? RD_DATA : IDLE;
            WR_DATA: state_d = w_end ? WR_RESP : WR_DATA;
            WR_RESP: state_d = axi_req_i.b_ready ? IDLE : WR_RESP;
            RD_DATA: state_d = r_hs && r_last_q ? IDLE : RD_DATA;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_rdy;
        axi_rsp_o.ar_ready = ar_rdy;
        axi_rsp_o.w_ready  = state_q == WR_DATA;
        axi_rsp_o.b_valid  = state_q == WR_RESP;
        axi_rsp_o.b.id     = id_q;
        axi_rsp_o.b.resp   = resp_code(dec_q, slv_q);
        axi_rsp_o.r_valid  = r_valid_q;
        axi_rsp_o.r.id     = id_q;
        axi_rsp_o.r.resp   = r_resp_q;
        axi_rsp_o.r.last   = r_last_q;
        axi_rsp_o.r.data   = r_valid_q && !r_zero_q ? rdata : '0;
    end

endmodule

// File: tb/tb_axi_pack_mem_responder.sv
// tb_axi_pack_mem_responder: directed self-checking bench for axi_pack_mem_responder.
module tb_axi_pack_mem_responder;
    import axi_pack_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    axi_idext_req_t req = '0;
    axi_idext_rsp_t rsp;
    int checks = 0;
    int failures = 0;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic [8:0]  rd_id [16];
    logic        rd_last [16];

    always #5 clk = ~clk;

    axi_pack_mem_responder dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .axi_req_i (req),
        .axi_rsp_o (rsp)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        req.aw = '0;
        req.aw.id = id;
        req.aw.addr = addr;
        req.aw.len = len;
        req.aw.size = 3'd2;
        req.aw.burst = burst;
        req.aw_valid = 1'b1;
        @(negedge clk);
        while (!rsp.aw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp.aw_ready) begin
            failures++;
            $display("FAIL aw_handshake got=timeout required=aw_ready");
        end
        step();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        req.ar = '0;
        req.ar.id = id;
        req.ar.addr = addr;
        req.ar.len = len;
        req.ar.size = 3'd2;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
        @(negedge clk);
        while (!rsp.ar_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp.ar_ready) begin
            failures++;
            $display("FAIL ar_handshake got=timeout required=ar_ready");
        end
        step();
        req.ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        n = 0;
        req.w = '0;
        req.w.data = data;
        req.w.strb = strb;
        req.w.last = last;
        req.w_valid = 1'b1;
        @(negedge clk);
        while (!rsp.w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp.w_ready) begin
            failures++;
            $display("FAIL w_handshake got=timeout required=w_ready");
        end
        step();
        req.w_valid = 1'b0;
    endtask

    task automatic get_b(output logic [8:0] id, output logic [1:0] resp);
        int n;
        n = 0;
        req.b_ready = 1'b1;
        @(negedge clk);
        while (!rsp.b_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp.b_valid) begin
            failures++;
            $display("FAIL b_handshake got=timeout required=b_valid");
        end
        id = rsp.b.id;
        resp = rsp.b.resp;
        step();
        req.b_ready = 1'b0;
    endtask

    task automatic get_r(input int cnt, output int gaps);
        int n;
        gaps = 0;
        req.r_ready = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            n = 0;
            @(negedge clk);
            while (!rsp.r_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!rsp.r_valid) begin
                failures++;
                $display("FAIL r_beat%0d got=timeout required=r_valid", k);
            end
            gaps += n;
            rd_data[k] = rsp.r.data;
            rd_resp[k] = rsp.r.resp;
            rd_id[k] = rsp.r.id;
            rd_last[k] = rsp.r.last;
            step();
        end
        req.r_ready = 1'b0;
    endtask

    task automatic write1(input logic [8:0] id, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [8:0] bid, output logic [1:0] bresp);
        send_aw(id, addr, 8'd0, BURST_INCR);
        send_w(data, strb, 1'b1);
        get_b(bid, bresp);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", rsp);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d required=%0d", dut.state_q, IDLE);
        end
        step();
        rst_ni = 1'b1;
        step();
        step();
        checks++;
        if (rsp.aw_ready !== 1'b1 || rsp.ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_readies got=%b%b required=11", rsp.aw_ready, rsp.ar_ready);
        end
    endtask

    task automatic test_arbitration;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        req.aw = '0;
        req.aw.id = 9'h011;
        req.aw.addr = 32'h100;
        req.aw.size = 3'd2;
        req.aw.burst = BURST_INCR;
        req.ar = '0;
        req.ar.id = 9'h022;
        req.ar.addr = 32'h100;
        req.ar.size = 3'd2;
        req.ar.burst = BURST_INCR;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp.aw_ready !== 1'b1 || rsp.ar_ready !== 1'b0) begin
            failures++;
            $display("FAIL arb_first got=aw%b_ar%b required=aw1_ar0", rsp.aw_ready, rsp.ar_ready);
        end
        step();
        req.aw_valid = 1'b0;
        send_w(32'hCAFE0001, 4'hF, 1'b1);
        req.aw.id = 9'h033;
        req.aw.addr = 32'h104;
        req.aw_valid = 1'b1;
        get_b(id, resp);
        checks++;
        if (id !== 9'h011 || resp !== RESP_OKAY) begin
            failures++;
            $display("FAIL arb_b1 got=id%h_resp%0d required=id011_resp0", id, resp);
        end
        @(negedge clk);
        checks++;
        if (rsp.aw_ready !== 1'b0 || rsp.ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL arb_second got=aw%b_ar%b required=aw0_ar1", rsp.aw_ready, rsp.ar_ready);
        end
        step();
        req.ar_valid = 1'b0;
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'hCAFE0001 || rd_id[0] !== 9'h022) begin
            failures++;
            $display("FAIL arb_r got=%h_id%h required=cafe0001_id022", rd_data[0], rd_id[0]);
        end
        send_aw(9'h033, 32'h104, 8'd0, BURST_INCR);
        send_w(32'hCAFE0002, 4'hF, 1'b1);
        get_b(id, resp);
        checks++;
        if (id !== 9'h033 || resp !== RESP_OKAY) begin
            failures++;
            $display("FAIL arb_b2 got=id%h_resp%0d required=id033_resp0", id, resp);
        end
    endtask

    task automatic test_single;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        write1(9'h1A5, 32'h10, 32'hDEADBEEF, 4'hF, id, resp);
        checks++;
        if (id !== 9'h1A5 || resp !== RESP_OKAY) begin
            failures++;
            $display("FAIL single_b got=id%h_resp%0d required=id1a5_resp0", id, resp);
        end
        send_ar(9'h0C3, 32'h10, 8'd0, BURST_INCR);
        checks++;
        if (rsp.r_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_r_latency got=%b required=1", rsp.r_valid);
        end
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_id[0] !== 9'h0C3 || rd_resp[0] !== RESP_OKAY) begin
            failures++;
            $display("FAIL single_r got=%h_l%b_id%h_resp%0d required=deadbeef_l1_id0c3_resp0",
                     rd_data[0], rd_last[0], rd_id[0], rd_resp[0]);
        end
    endtask

    task automatic test_incr;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        send_aw(9'h005, 32'h40, 8'd3, BURST_INCR);
        for (int i = 1; i <= 4; i++) send_w(32'(i), 4'hF, i == 4);
        get_b(id, resp);
        checks++;
        if (id !== 9'h005 || resp !== RESP_OKAY) begin
            failures++;
            $display("FAIL incr_b got=id%h_resp%0d required=id005_resp0", id, resp);
        end
        send_ar(9'h006, 32'h40, 8'd3, BURST_INCR);
        get_r(4, gaps);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL incr_beat%0d got=%h_l%b required=%h_l%b", i, rd_data[i], rd_last[i], i + 1, i == 3);
            end
        end
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL incr_back_to_back got=%0d required=0 idle cycles", gaps);
        end
    endtask

    task automatic test_strobe;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        write1(9'h007, 32'h20, 32'h11223344, 4'hF, id, resp);
        write1(9'h008, 32'h20, 32'hAABBCCDD, 4'h5, id, resp);
        send_ar(9'h009, 32'h20, 8'd0, BURST_INCR);
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL strobe got=%h required=11bb33dd", rd_data[0]);
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] id;
        logic [1:0] resp;
        logic [31:0] got [8];
        logic [31:0] held;
        logic [7:0] lastv;
        logic stall;
        bit [3:0] pat;
        int beats, bad, c;
        beats = 0;
        bad = 0;
        c = 0;
        stall = 1'b0;
        held = '0;
        lastv = '0;
        pat = 4'b1001;
        send_aw(9'h0A0, 32'h200, 8'd7, BURST_INCR);
        for (int i = 0; i < 8; i++) send_w(32'hB0 + 32'(i), 4'hF, i == 7);
        get_b(id, resp);
        send_ar(9'h0AA, 32'h200, 8'd7, BURST_INCR);
        while (beats < 8 && c < 80) begin
            req.r_ready = pat[c % 4];
            @(negedge clk);
            if (stall && (!rsp.r_valid || rsp.r.data !== held)) bad++;
            stall = rsp.r_valid && !req.r_ready;
            held = rsp.r.data;
            if (rsp.r_valid && req.r_ready) begin
                got[beats] = rsp.r.data;
                lastv[beats] = rsp.r.last;
                beats++;
            end
            step();
            c++;
        end
        req.r_ready = 1'b0;
        step();
        checks++;
        if (beats != 8) begin
            failures++;
            $display("FAIL bp_beats got=%0d required=8", beats);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stall_stable got=%0d required=0 changes", bad);
        end
        checks++;
        if (lastv !== 8'h80) begin
            failures++;
            $display("FAIL bp_last got=%b required=10000000", lastv);
        end
        checks++;
        if (rsp.r_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_extra_beat got=%b required=0", rsp.r_valid);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== 32'hB0 + 32'(i)) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h required=%h", i, got[i], 32'hB0 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        write1(9'h043, 32'h80, 32'h12345678, 4'hF, id, resp);
        send_aw(9'h044, 32'h80, 8'd1, BURST_WRAP);
        send_w(32'hFFFFFFFF, 4'hF, 1'b0);
        send_w(32'hFFFFFFFF, 4'hF, 1'b1);
        get_b(id, resp);
        checks++;
        if (id !== 9'h044 || resp !== RESP_SLVERR) begin
            failures++;
            $display("FAIL wrap_b got=id%h_resp%0d required=id044_resp2", id, resp);
        end
        send_ar(9'h045, 32'h80, 8'd0, BURST_INCR);
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'h12345678 || rd_resp[0] !== RESP_OKAY) begin
            failures++;
            $display("FAIL wrap_mem got=%h_resp%0d required=12345678_resp0", rd_data[0], rd_resp[0]);
        end
        send_ar(9'h046, 32'h80, 8'd1, BURST_WRAP);
        get_r(2, gaps);
        checks++;
        if (rd_resp[0] !== RESP_SLVERR || rd_resp[1] !== RESP_SLVERR || rd_last[1] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_r got=%0d_%0d_l%b required=2_2_l1", rd_resp[0], rd_resp[1], rd_last[1]);
        end
    endtask

    task automatic test_last_mismatch;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        send_aw(9'h047, 32'h90, 8'd3, BURST_INCR);
        send_w(32'h1, 4'hF, 1'b0);
        send_w(32'h2, 4'hF, 1'b1);
        get_b(id, resp);
        checks++;
        if (id !== 9'h047 || resp !== RESP_SLVERR) begin
            failures++;
            $display("FAIL early_last_b got=id%h_resp%0d required=id047_resp2", id, resp);
        end
        send_aw(9'h048, 32'h98, 8'd0, BURST_INCR);
        send_w(32'h3, 4'hF, 1'b0);
        get_b(id, resp);
        checks++;
        if (id !== 9'h048 || resp !== RESP_SLVERR) begin
            failures++;
            $display("FAIL missing_last_b got=id%h_resp%0d required=id048_resp2", id, resp);
        end
        send_ar(9'h049, 32'h94, 8'd0, BURST_INCR);
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'h2) begin
            failures++;
            $display("FAIL early_last_data got=%h required=00000002", rd_data[0]);
        end
    endtask

    task automatic test_range;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        write1(9'h070, 32'h0, 32'h5A5A0000, 4'hF, id, resp);
        send_ar(9'h077, 32'h1000, 8'd0, BURST_INCR);
        get_r(1, gaps);
        write1(9'h078, 32'h1004, 32'h0BAD0BAD, 4'hF, id, resp);
`ifdef AXI_PACK_MEM_RESP_ERR_EN
        checks++;
        if (rd_resp[0] !== RESP_DECERR || rd_data[0] !== 32'h0) begin
            failures++;
            $display("FAIL oor_read got=%h_resp%0d required=00000000_resp3", rd_data[0], rd_resp[0]);
        end
        checks++;
        if (resp !== RESP_DECERR) begin
            failures++;
            $display("FAIL oor_write got=%0d required=3", resp);
        end
`else
        checks++;
        if (rd_resp[0] !== RESP_OKAY || rd_data[0] !== 32'h5A5A0000) begin
            failures++;
            $display("FAIL wrap_index_read got=%h_resp%0d required=5a5a0000_resp0", rd_data[0], rd_resp[0]);
        end
        checks++;
        if (resp !== RESP_OKAY) begin
            failures++;
            $display("FAIL wrap_index_write got=%0d required=0", resp);
        end
        send_ar(9'h079, 32'h4, 8'd0, BURST_INCR);
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'h0BAD0BAD) begin
            failures++;
            $display("FAIL wrap_index_alias got=%h required=0bad0bad", rd_data[0]);
        end
`endif
    endtask

    task automatic test_reset_mid;
        logic [8:0] id;
        logic [1:0] resp;
        int gaps;
        send_ar(9'h0EE, 32'h200, 8'd7, BURST_INCR);
        get_r(2, gaps);
        rst_ni = 1'b0;
        #2;
        checks++;
        if (rsp !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h required=0", rsp);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL mid_reset_state got=%0d required=%0d", dut.state_q, IDLE);
        end
        step();
        rst_ni = 1'b1;
        req.r_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (rsp.r_valid !== 1'b0 || rsp.aw_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset got=rv%b_awr%b required=rv0_awr1", rsp.r_valid, rsp.aw_ready);
        end
        req.r_ready = 1'b0;
        write1(9'h0EF, 32'h300, 32'h600DF00D, 4'hF, id, resp);
        send_ar(9'h0F0, 32'h300, 8'd0, BURST_INCR);
        get_r(1, gaps);
        checks++;
        if (rd_data[0] !== 32'h600DF00D || rd_id[0] !== 9'h0F0) begin
            failures++;
            $display("FAIL post_reset_rw got=%h_id%h required=600df00d_id0f0", rd_data[0], rd_id[0]);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single();
        test_incr();
        test_strobe();
        test_backpressure();
        test_wrap();
        test_last_mismatch();
        test_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_pack_mem_responder.md
Name: axi_pack_mem_responder

Overview:
- AXI4 subordinate (responder) that terminates the ID-extended memory-side bus driven by the packing filter; it is the far end of the filter's request path.
- Serves reads and writes from an internal word-addressed SRAM model, echoes IDs and generates B/R responses.
- Used as the memory endpoint in filter testbenches and as a scratchpad in small subsystems.
- Serves one transaction at a time: no reordering, no interleaving.

Parameters:
- MemWords, 1024: number of DataWidth-bit words in the array; must be a power of two.
- BaseAddr, 32'h0000_0000: byte address of word 0.
- axi_req_t, axi_idext_req_t: request struct (9-bit ID).
- axi_rsp_t, axi_idext_rsp_t: response struct.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- axi_req_i  in  $bits(axi_req_t)  AW/W/AR channels, valids and B/R readies.
- axi_rsp_o  out  $bits(axi_rsp_t)  AW/W/AR readies, B/R channels and valids.

Behaviour:
- Reset:
  - All readies and valids are 0; b.id, b.resp, r.* are 0; FSM is in IDLE.
  - Memory contents are not reset.
  - Reset asserted mid-burst aborts the burst. No further beats or responses are issued.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE:
  - aw_ready and ar_ready are 1 only in IDLE.
  - Only one of aw_ready and ar_ready is effectively granted per cycle.
  - If only aw_valid is 1, accept AW and go to WR_DATA. If only ar_valid is 1, accept AR and go to RD_DATA.
  - If both are valid: round-robin, write first after reset, and the priority toggles after each grant. The non-granted ready is 0 that cycle.
- Latched on accept: id, addr, len, size, burst, and a beat counter set to 0.
- WR_DATA:
  - w_ready is 1. On each W handshake, write the byte lanes selected by strb into the current word.
  - On the beat with w.last=1, or when the counter reaches len, go to WR_RESP.
  - A w.last that does not match len also ends the burst; the extra or missing beats are reported as SLVERR.
- WR_RESP:
  - b_valid=1 with b.id equal to the latched id. Hold until b_ready, then return to IDLE.
- RD_DATA:
  - An output register holds one beat. r_valid rises 1 cycle after AR acceptance.
  - A new word is read whenever the register is empty or r_ready=1, so a stall-free burst runs at one beat per cycle.
  - r.id equals the latched id; r.last=1 when the counter equals len.
  - After the last handshake, return to IDLE. r_valid holds all fields stable until r_ready.
- Addressing:
  - Word index = (addr - BaseAddr) >> DataAlign.
  - INCR increments the word index each beat. FIXED repeats the same word.
  - WRAP is answered with SLVERR on every beat or on B; writes under WRAP are discarded.
  - size < DataAlign is accepted; strb governs the written bytes and reads return the full word.
- B/R user fields are driven 0. AW/AR/W user fields (ssr_user_t) are ignored.
- Response priority: DECERR overrides SLVERR, which overrides OKAY.

Optional Feature:
- Macro: AXI_PACK_MEM_RESP_ERR_EN.
- Defined:
  - Any beat whose word index is at or beyond MemWords gets DECERR on that R beat, or DECERR on B for the write.
  - Out-of-range write beats are discarded. Out-of-range read beats return data 0.
- Undefined:
  - The index is taken modulo MemWords and the response is always OKAY (WRAP still gives SLVERR).

Decomposition:
- Add to axi_pack_filter_parallel_wrap_pkg: the responder state enum, MemWords default and resp code localparams.
- Reuse the existing axi_idext_* typedefs unchanged.
- One sub-module: axi_pack_mem_responder_sram, a single-port byte-enabled array with a 1-cycle registered read and a write-enable per byte.

Test Plan:
- Single write then read: AW addr 0x10 id 0x1A5 len 0, W data 0xDEADBEEF strb 0xF → B id 0x1A5 OKAY. Then AR addr 0x10 → R data 0xDEADBEEF, last=1, 1 cycle after AR accept.
- INCR burst: AW addr 0x40 len 3 with data 1..4, strb 0xF → read burst len 3 returns 1,2,3,4 back-to-back; last asserted only on beat 4.
- Partial strobe: word holds 0x11223344; write 0xAABBCCDD with strb 0x5 → read returns 0x11BB33DD.
- R back-pressure: r_ready toggled 1,0,0,1 during a len 7 read → data stable while stalled, no beat lost or duplicated, 8 beats total.
- Arbitration: AW and AR both valid in the same cycle, twice in a row → write granted first, then read; B and R carry the correct ids.
- Errors:
  - With AXI_PACK_MEM_RESP_ERR_EN: read at BaseAddr + 4*MemWords → R DECERR, data 0.
  - WRAP write → B SLVERR and memory unchanged.
  - Reset pulsed mid-burst → all valids 0 and FSM in IDLE.
